// File: rtl/axi_lite_rd_arb.sv
// axi_lite_rd_arb
// Arbitrates read requests from two AXI-lite masters (m0 = IFU, m1 = LSU)
// onto one downstream AXI-lite read slave. Only one transaction is in
// flight at a time. The winner's address is captured at the handshake, and
// the slave's read beat is routed back to the granted master.
//
// Ports
//   clk, rst                : clock, synchronous active-low reset
//   m0_* / m1_*             : upstream AR/R channels (addr 32b, data 64b)
//   s_*                     : downstream AR/R channels
//
// Configuration
//   AXI_ARB_ROUND_ROBIN_EN  : when defined, ties go to the master that did
//                             not win last time. When undefined, m1 always
//                             wins ties.
//
// State | Meaning
// IDLE  | no transaction; a request is granted combinationally
// AR    | address driven downstream, waiting for s_arready
// R     | waiting for the read data beat from the slave
module axi_lite_rd_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_araddr,
  input  logic        m0_arvalid,
  output logic        m0_arready,
  output logic [63:0] m0_rdata,
  output logic [1:0]  m0_rresp,
  output logic        m0_rvalid,
  input  logic        m0_rready,
  input  logic [31:0] m1_araddr,
  input  logic        m1_arvalid,
  output logic        m1_arready,
  output logic [63:0] m1_rdata,
  output logic [1:0]  m1_rresp,
  output logic        m1_rvalid,
  input  logic        m1_rready,
  output logic [31:0] s_araddr,
  output logic        s_arvalid,
  input  logic        s_arready,
  input  logic [63:0] s_rdata,
  input  logic [1:0]  s_rresp,
  input  logic        s_rvalid,
  output logic        s_rready
);

  typedef enum logic [1:0] {IDLE = 2'd0, AR = 2'd1, R = 2'd2} state_t;

  state_t      state, state_nxt;
  logic        grant;      // 0 = m0, 1 = m1
  logic [31:0] addr_q;
  logic        any_req;
  logic        win1;
  logic        rready_sel;

`ifdef AXI_ARB_ROUND_ROBIN_EN
  logic        last_grant;
`endif

  // Winner selection; only meaningful while in IDLE.
  always_comb begin
    any_req = m0_arvalid | m1_arvalid;
`ifdef AXI_ARB_ROUND_ROBIN_EN
    if (m0_arvalid && m1_arvalid) win1 = ~last_grant;
    else                          win1 = m1_arvalid;
`else
    win1 = m1_arvalid;
`endif
  end

  assign rready_sel = grant ? m1_rready : m0_rready;

  // State register plus grant/address capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      grant  <= 1'b0;
      addr_q <= '0;
`ifdef AXI_ARB_ROUND_ROBIN_EN
      last_grant <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) begin
        grant  <= win1;
        addr_q <= win1 ? m1_araddr : m0_araddr;
`ifdef AXI_ARB_ROUND_ROBIN_EN
        last_grant <= win1;
`endif
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = AR;
      AR:      if (s_arready) state_nxt = R;
      R:       if (s_rvalid && rready_sel) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs. Everything is forced to 0 while rst is low so that the reset
  // cycle itself shows a quiet interface, not only the cycle after it.
  always_comb begin
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rvalid  = 1'b0;
    m0_rdata   = '0;
    m1_rdata   = '0;
    m0_rresp   = '0;
    m1_rresp   = '0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    s_araddr   = rst ? addr_q : '0;
    if (rst) begin
      case (state)
        IDLE: begin
          m0_arready = any_req & ~win1;
          m1_arready = win1;
        end
        AR: s_arvalid = 1'b1;
        R: begin
          s_rready = rready_sel;
          if (grant) begin
            m1_rvalid = s_rvalid;
            m1_rdata  = s_rdata;
            m1_rresp  = s_rresp;
          end else begin
            m0_rvalid = s_rvalid;
            m0_rdata  = s_rdata;
            m0_rresp  = s_rresp;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
